// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one clocked write port, r0 hardwired to zero.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file #(
    parameter int bit_size  = 32,
    parameter int addr_size = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_write,
    input  logic [addr_size-1:0] write_reg,
    input  logic [bit_size-1:0]  write_data,
    input  logic [addr_size-1:0] read_reg1,
    input  logic [addr_size-1:0] read_reg2,
    output logic [bit_size-1:0]  read_data1,
    output logic [bit_size-1:0]  read_data2
);

    localparam int depth = 1 << addr_size;

    logic [bit_size-1:0] regs_r [depth];
    logic                wr_en_s;

    // Index 0 is excluded here so it is never written, not even for one cycle.
    assign wr_en_s = reg_write && (write_reg != {addr_size{1'b0}});

    // Register storage: asynchronous clear, single writeback port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < depth; i++) begin
                regs_r[i] <= {bit_size{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[write_reg] <= write_data;
        end
    end

    // Read port 1 (rs).
    always_comb begin
        read_data1 = {bit_size{1'b0}};
        if (read_reg1 == {addr_size{1'b0}}) begin
            read_data1 = {bit_size{1'b0}};
`ifdef REG_FILE_BYPASS_EN
        end else if (wr_en_s && (write_reg == read_reg1)) begin
            read_data1 = write_data;
`endif
        end else begin
            read_data1 = regs_r[read_reg1];
        end
    end

    // Read port 2 (rt).
    always_comb begin
        read_data2 = {bit_size{1'b0}};
        if (read_reg2 == {addr_size{1'b0}}) begin
            read_data2 = {bit_size{1'b0}};
`ifdef REG_FILE_BYPASS_EN
        end else if (wr_en_s && (write_reg == read_reg2)) begin
            read_data2 = write_data;
`endif
        end else begin
            read_data2 = regs_r[read_reg2];
        end
    end

endmodule
